// File: rtl/disp_q.sv
// disp_q: in-order dispatch queue between rename and one reservation station.
// Renamed uops sit in a circular buffer; the oldest is offered to the rs every cycle.

typedef struct packed {
  logic [7:0] op;
  logic [5:0] pdst;
  logic [5:0] psrc1;
  logic [5:0] psrc2;
  logic [7:0] tag;
} t_uinstr_disp;

typedef struct packed {
  logic       valid;
  logic [7:0] rob_id;
} t_nuke_pkt;

module disp_q #(
  parameter int DEPTH   = 4,
  parameter     DQ_NAME = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  t_nuke_pkt             nuke_rb1,
  input  logic                  rename_valid_rn2,
  input  t_uinstr_disp          rename_pkt_rn2,
  output logic                  rename_stall_rn2,
  output logic                  disp_valid_rs0,
  output t_uinstr_disp          disp_pkt_rs0,
  input  logic                  rs_stall_rs0,
  output logic [$clog2(DEPTH):0] dq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Both ports use valid/stall: a uop moves in a cycle where valid is high
  // and stall is low. Our own stall depends only on registered occupancy.

  t_uinstr_disp   entry_q [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  cnt;
  logic           nuke;
  logic           enq;
  logic           deq;
  logic           unused_nuke_bits;

  assign nuke             = nuke_rb1.valid;
  assign unused_nuke_bits = ^nuke_rb1.rob_id;

  assign rename_stall_rn2 = (cnt == CW'(DEPTH));
  assign disp_valid_rs0   = (cnt != '0) & ~nuke;
  assign disp_pkt_rs0     = entry_q[rd_ptr];
  assign dq_count         = cnt;

  assign enq = rename_valid_rn2 & ~rename_stall_rn2 & ~nuke;
  assign deq = disp_valid_rs0 & ~rs_stall_rs0;

  always_ff @(posedge clk) begin
    if (reset || nuke) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq);
      rd_ptr <= rd_ptr + PW'(deq);
      cnt    <= cnt + CW'(enq) - CW'(deq);
    end
  end

  // Payload storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_q[wr_ptr] <= rename_pkt_rn2;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (rename_valid_rn2 && rename_stall_rn2) begin
        $error("%s: rename uop presented while queue is stalling", DQ_NAME);
      end
      if (cnt > CW'(DEPTH)) begin
        $error("%s: occupancy %0d exceeds depth", DQ_NAME, cnt);
      end
      if (deq) begin
        $info("UINFO unit:%s func:disp", DQ_NAME);
      end
    end
  end
`endif

endmodule

// File: tb/tb_disp_q.sv
// tb_disp_q: directed bench for disp_q with a queue-based reference model
// compared every cycle, plus hand-computed literal expectations per scenario.

module tb_disp_q;

  localparam int DEPTH = 4;
  localparam int PKT_W = 34;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [8:0]       nuke_rb1;
  logic             rename_valid_rn2;
  logic [PKT_W-1:0] rename_pkt_rn2;
  logic             rename_stall_rn2;
  logic             disp_valid_rs0;
  logic [PKT_W-1:0] disp_pkt_rs0;
  logic             rs_stall_rs0;
  logic [CW-1:0]    dq_count;

  int checks   = 0;
  int failures = 0;

  logic [PKT_W-1:0] exp_q[$];
  logic [7:0]       out_log[$];
  bit               model_live = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  disp_q #(.DEPTH(DEPTH), .DQ_NAME("dq0")) dut (
    .clk              (clk),
    .reset            (reset),
    .nuke_rb1         (nuke_rb1),
    .rename_valid_rn2 (rename_valid_rn2),
    .rename_pkt_rn2   (rename_pkt_rn2),
    .rename_stall_rn2 (rename_stall_rn2),
    .disp_valid_rs0   (disp_valid_rs0),
    .disp_pkt_rs0     (disp_pkt_rs0),
    .rs_stall_rs0     (rs_stall_rs0),
    .dq_count         (dq_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [PKT_W-1:0] mk(input logic [7:0] tag);
    logic [7:0] t;
    t = tag;
    return {t ^ 8'h5a, t[5:0], ~t[5:0], t[7:2], t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic [7:0] tag, input logic rs, input logic nk);
    rename_valid_rn2 = v;
    rename_pkt_rn2   = mk(tag);
    rs_stall_rs0     = rs;
    nuke_rb1         = {nk, 8'h3c};
  endtask

  // One cycle: compare DUT against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic exp_valid;
    bit   do_enq;
    bit   do_deq;
    @(negedge clk);
    if (model_live) begin
      exp_valid = (exp_q.size() != 0) && !nuke_rb1[8];
      check("cyc_stall", rename_stall_rn2, exp_q.size() == DEPTH);
      check("cyc_valid", disp_valid_rs0, exp_valid);
      check("cyc_count", dq_count, exp_q.size());
      if (exp_valid) check("cyc_pkt", disp_pkt_rs0, exp_q[0]);
      if (disp_valid_rs0 && !rs_stall_rs0) out_log.push_back(disp_pkt_rs0[7:0]);
    end
    @(posedge clk);
    if (reset || nuke_rb1[8]) begin
      exp_q.delete();
    end else begin
      do_deq = (exp_q.size() != 0) && !rs_stall_rs0;
      do_enq = rename_valid_rn2 && (exp_q.size() < DEPTH);
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) exp_q.push_back(rename_pkt_rn2);
    end
    if (reset) model_live = 1'b1;
    #1;
  endtask

  task automatic idle(input logic rs);
    drive(1'b0, 8'h00, rs, 1'b0);
    tick();
  endtask

  task automatic fill(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 8'(first + i), 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic check_log(input string name, input logic [7:0] first, input int n);
    check({name, "_len"}, out_log.size(), n);
    for (int i = 0; i < n && i < out_log.size(); i++) begin
      check({name, "_order"}, out_log[i], 8'(first + i));
    end
  endtask

  initial begin
    logic [7:0] tag;
    logic       v;

    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_stall", rename_stall_rn2, 0);
    check("rst_valid", disp_valid_rs0, 0);
    check("rst_count", dq_count, 0);

    // single uop: offered the cycle after enqueue, then drained
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    #1 check("t1_no_bypass", disp_valid_rs0, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("t1_valid", disp_valid_rs0, 1);
    check("t1_pkt", disp_pkt_rs0, mk(8'h10));
    check("t1_count", dq_count, 1);
    tick();
    check("t1_count_after", dq_count, 0);

    // rs stalls while the queue fills, then releases
    out_log.delete();
    fill(8'h21, 4);
    check("t2_stall", rename_stall_rn2, 1);
    check("t2_count", dq_count, 4);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check_log("t2", 8'h21, 4);
    check("t2_empty", dq_count, 0);

    // full queue, rs accepting and rename offering whenever allowed
    out_log.delete();
    fill(8'h31, 4);
    tag = 8'h35;
    for (int c = 0; c < 8; c++) begin
      v = !rename_stall_rn2;
      drive(v, tag, 1'b0, 1'b0);
      if (v) tag = tag + 8'h01;
      tick();
      if (c == 0) check("t3_stall_drop", rename_stall_rn2, 0);
    end
    check("t3_count", dq_count, 3);
    for (int i = 0; i < 3; i++) idle(1'b0);
    check_log("t3", 8'h31, 11);

    // simultaneous enq/deq at occupancy 2 across pointer wrap
    out_log.delete();
    fill(8'h41, 2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h43 + i), 1'b0, 1'b0);
      tick();
      check("t4_count", dq_count, 2);
    end
    idle(1'b0);
    idle(1'b0);
    check_log("t4", 8'h41, 12);

    // nuke with a colliding rename uop
    out_log.delete();
    fill(8'h51, 3);
    drive(1'b1, 8'h54, 1'b0, 1'b1);
    #1 check("t5_nuke_valid", disp_valid_rs0, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("t5_count", dq_count, 0);
    check("t5_stall", rename_stall_rn2, 0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    check("t5_nothing_out", out_log.size(), 0);

    // reset mid-stream
    fill(8'h61, 2);
    reset = 1'b1;
    drive(1'b1, 8'h63, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    out_log.delete();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("t6_count", dq_count, 0);
    check("t6_valid", disp_valid_rs0, 0);
    check("t6_stall", rename_stall_rn2, 0);
    drive(1'b1, 8'h64, 1'b0, 1'b0);
    #1 check("t6_no_bypass", disp_valid_rs0, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("t6_valid_after", disp_valid_rs0, 1);
    check("t6_pkt", disp_pkt_rs0, mk(8'h64));
    tick();
    check("t6_count_after", dq_count, 0);
    check_log("t6", 8'h64, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
